// File: rtl/poly_mult_pkg.sv
// rtl/poly_mult_pkg.sv - shared types, constants and sizing helpers for the polynomial multiplier
package poly_mult_pkg;

    parameter int COEFF_WIDTH = 8;
    localparam int DEFAULT_LATENCY = 5;

    typedef logic [COEFF_WIDTH-1:0] coeff_t;

    // Number of pairwise-add levels needed to reduce n operands to one.
    function automatic int tree_depth(input int n);
        int d;
        d = 0;
        while ((1 << d) < n) begin
            d++;
        end
        return d;
    endfunction

    // Operands still alive after `level` rounds of pairwise reduction.
    function automatic int level_count(input int n, input int level);
        return (n + (1 << level) - 1) >> level;
    endfunction

endpackage

// File: rtl/pipelined_adder_tree.sv
// rtl/pipelined_adder_tree.sv - registered wrapping pairwise adder tree with valid/first/last sideband
module pipelined_adder_tree
    import poly_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [N-1:0][WIDTH-1:0]  operands,
    output logic                     out_valid,
    output logic                     out_first,
    output logic                     out_last,
    output logic [WIDTH-1:0]         sum
);

    localparam int DEPTH = tree_depth(N);

    for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
        localparam int CNT = level_count(N, l);
        logic [WIDTH-1:0] data [CNT];
        logic             valid;
        logic             first;
        logic             last;

        if (l == 0) begin : g_in
            for (genvar j = 0; j < CNT; j++) begin : g_op
                assign data[j] = operands[j];
            end
            assign valid = in_valid;
            assign first = in_first;
            assign last  = in_last;
        end else begin : g_reg
            localparam int PREV = level_count(N, l - 1);
            logic [WIDTH-1:0] lo [CNT];
            logic [WIDTH-1:0] hi [CNT];

            // An odd leftover pairs with zero, so it passes through registered.
            for (genvar j = 0; j < CNT; j++) begin : g_pair
                assign lo[j] = g_lvl[l-1].data[2*j];
                if (2*j + 1 < PREV) begin : g_two
                    assign hi[j] = g_lvl[l-1].data[2*j+1];
                end else begin : g_one
                    assign hi[j] = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid <= 1'b0;
                    first <= 1'b0;
                    last  <= 1'b0;
                    for (int j = 0; j < CNT; j++) begin
                        data[j] <= '0;
                    end
                end else if (en) begin
                    valid <= g_lvl[l-1].valid;
                    first <= g_lvl[l-1].first;
                    last  <= g_lvl[l-1].last;
                    for (int j = 0; j < CNT; j++) begin
                        data[j] <= lo[j] + hi[j];
                    end
                end
            end
        end
    end

    assign sum       = g_lvl[DEPTH].data[0];
    assign out_valid = g_lvl[DEPTH].valid;
    assign out_first = g_lvl[DEPTH].first;
    assign out_last  = g_lvl[DEPTH].last;

endmodule

// File: rtl/accumulating_column.sv
// rtl/accumulating_column.sv - pipelined multi-beat dot-product column with negacyclic wrap and fixed latency
module accumulating_column
    import poly_mult_pkg::*;
#(
    parameter int COEFF_WIDTH = 8,
    parameter int MAX_HEIGHT  = 8,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [MAX_HEIGHT-1:0][COEFF_WIDTH-1:0] as,
    input  logic [MAX_HEIGHT-1:0][COEFF_WIDTH-1:0] bs,
    input  logic [MAX_HEIGHT-1:0]                 term_en,
    input  logic [MAX_HEIGHT-1:0]                 term_neg,
    input  logic                                  in_first,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [COEFF_WIDTH-1:0]                c_value
);

    localparam int TREE_DEPTH = tree_depth(MAX_HEIGHT);
    localparam int D          = LATENCY - TREE_DEPTH - 2;

    if (LATENCY < TREE_DEPTH + 2) begin : g_latency_check
        $error("accumulating_column: LATENCY must be at least TREE_DEPTH+2");
    end

    // One global stall: the whole pipe freezes while the output is blocked.
    logic advance;
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    logic [MAX_HEIGHT-1:0][COEFF_WIDTH-1:0] terms;
    for (genvar i = 0; i < MAX_HEIGHT; i++) begin : g_lane
        logic [COEFF_WIDTH-1:0] prod;
        assign prod     = as[i] * bs[MAX_HEIGHT-1-i];
        assign terms[i] = term_en[i] ? (term_neg[i] ? -prod : prod) : '0;
    end

    logic [MAX_HEIGHT-1:0][COEFF_WIDTH-1:0] p;
    logic                                   p_valid;
    logic                                   p_first;
    logic                                   p_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            p       <= '0;
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
        end else if (advance) begin
            p       <= terms;
            p_valid <= in_valid;
            p_first <= in_first;
            p_last  <= in_last;
        end
    end

    logic                   t_valid;
    logic                   t_first;
    logic                   t_last;
    logic [COEFF_WIDTH-1:0] t_sum;

    pipelined_adder_tree #(
        .WIDTH (COEFF_WIDTH),
        .N     (MAX_HEIGHT)
    ) u_tree (
        .clk       (clk),
        .reset     (reset),
        .en        (advance),
        .in_valid  (p_valid),
        .in_first  (p_first),
        .in_last   (p_last),
        .operands  (p),
        .out_valid (t_valid),
        .out_first (t_first),
        .out_last  (t_last),
        .sum       (t_sum)
    );

    logic [COEFF_WIDTH-1:0] acc;
    logic [COEFF_WIDTH-1:0] acc_next;
    logic                   a_valid;
    logic [COEFF_WIDTH-1:0] a_value;

    assign acc_next = t_first ? t_sum : acc + t_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            a_valid <= 1'b0;
            a_value <= '0;
        end else if (advance) begin
            a_valid <= t_valid && t_last;
            if (t_valid) begin
                acc <= acc_next;
            end
            if (t_valid && t_last) begin
                a_value <= acc_next;
            end
        end
    end

    // Alignment delay pads every column instance out to the same LATENCY.
    if (D == 0) begin : g_no_delay
        assign out_valid = a_valid;
        assign c_value   = a_value;
    end else begin : g_delay
        logic                   dv   [D];
        logic [COEFF_WIDTH-1:0] dval [D];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < D; k++) begin
                    dv[k]   <= 1'b0;
                    dval[k] <= '0;
                end
            end else if (advance) begin
                dv[0]   <= a_valid;
                dval[0] <= a_value;
                for (int k = 1; k < D; k++) begin
                    dv[k]   <= dv[k-1];
                    dval[k] <= dval[k-1];
                end
            end
        end

        assign out_valid = dv[D-1];
        assign c_value   = dval[D-1];
    end

endmodule

// File: tb/tb_accumulating_column.sv
// tb/tb_accumulating_column.sv - self-checking bench for accumulating_column (defaults: 8-bit, 8 lanes, latency 5)
module tb_accumulating_column;

    localparam int L = 5;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0][7:0]       as_v;
    logic [7:0][7:0]       bs_v;
    logic [7:0]            term_en;
    logic [7:0]            term_neg;
    logic                  in_first;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            c_value;

    accumulating_column #(
        .COEFF_WIDTH (8),
        .MAX_HEIGHT  (8),
        .LATENCY     (L)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .as        (as_v),
        .bs        (bs_v),
        .term_en   (term_en),
        .term_neg  (term_neg),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_value   (c_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a column sum is plain modular arithmetic over the lanes; results
    // travel through L slots that move only when the output is not blocked.
    bit mv   [L];
    int mval [L];
    int macc;
    bit madv;

    function automatic int col_sum();
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if (term_en[i]) begin
                if (term_neg[i]) s -= int'(as_v[i]) * int'(bs_v[7-i]);
                else             s += int'(as_v[i]) * int'(bs_v[7-i]);
            end
        end
        return s & 255;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < L; k++) begin
                mv[k]   = 1'b0;
                mval[k] = 0;
            end
            macc = 0;
        end else begin
            madv = !(mv[L-1] && !out_ready);
            if (out_valid && out_ready) got.push_back(int'(c_value));
            if (madv) begin
                if (in_valid) macc = in_first ? col_sum() : (macc + col_sum()) & 255;
                for (int k = L - 1; k > 0; k--) begin
                    mv[k]   = mv[k-1];
                    mval[k] = mval[k-1];
                end
                mv[0]   = in_valid && in_last;
                mval[0] = macc;
            end
        end
        #1;
        check("out_valid", out_valid, mv[L-1]);
        if (mv[L-1]) check("c_value", c_value, mval[L-1]);
        check("in_ready", in_ready, !(mv[L-1] && !out_ready));
    end

    function automatic logic [7:0][7:0] ramp();
        logic [7:0][7:0] r;
        for (int i = 0; i < 8; i++) r[i] = 8'(i + 1);
        return r;
    endfunction

    function automatic logic [7:0][7:0] fill(input logic [7:0] v);
        logic [7:0][7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v;
        return r;
    endfunction

    function automatic logic [7:0][7:0] lane(input int idx, input logic [7:0] v);
        logic [7:0][7:0] r;
        r = '0;
        r[idx] = v;
        return r;
    endfunction

    task automatic send(input logic f, input logic l, input logic [7:0][7:0] a,
                        input logic [7:0][7:0] b, input logic [7:0] en, input logic [7:0] ng);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        as_v     = a;
        bs_v     = b;
        term_en  = en;
        term_neg = ng;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic expect_got(input string nm, input int n, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        check({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) check({nm, "_value"}, got[i], e[i]);
        got.delete();
    endtask

    task automatic column(input string nm, input logic [7:0][7:0] a, input logic [7:0][7:0] b,
                          input logic [7:0] en, input logic [7:0] ng, input int exp);
        send(1'b1, 1'b1, a, b, en, ng);
        idle();
        wait_got(1);
        expect_got(nm, 1, exp, 0, 0, 0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        as_v      = '0;
        bs_v      = '0;
        term_en   = '0;
        term_neg  = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_c_value", c_value, 0);
        reset = 1'b0;

        // Single beat: exact latency and a one-cycle output pulse.
        send(1'b1, 1'b1, ramp(), fill(8'd2), 8'hFF, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("single_latency", n, 5);
        check("single_value", c_value, 72);
        @(negedge clk);
        check("single_pulse", out_valid, 0);
        wait_got(1);
        expect_got("single", 1, 72, 0, 0, 0);

        column("wrap",     fill(8'd255), fill(8'd255), 8'hFF, 8'h00, 8);
        column("wrap_off", fill(8'd255), fill(8'd255), 8'h00, 8'h00, 0);
        column("neg_0f",   ramp(), fill(8'd2), 8'hFF, 8'h0F, 32);
        column("neg_ff",   ramp(), fill(8'd2), 8'hFF, 8'hFF, 184);

        // Three-beat column.
        send(1'b1, 1'b0, ramp(), fill(8'd2), 8'hFF, 8'h00);
        send(1'b0, 1'b0, ramp(), fill(8'd2), 8'hFF, 8'h00);
        send(1'b0, 1'b1, ramp(), fill(8'd2), 8'hFF, 8'h00);
        idle();
        wait_got(1);
        expect_got("multi", 1, 216, 0, 0, 0);

        // Backpressure: results held, then delivered in order.
        fork
            begin
                for (int k = 1; k <= 4; k++) send(1'b1, 1'b1, lane(0, 8'(k)), lane(7, 8'd1), 8'h01, 8'h00);
                idle();
            end
            begin
                int w;
                w = 0;
                while (!out_valid && w < 30) begin
                    @(negedge clk);
                    w++;
                end
                check("bp_first_seen", out_valid, 1);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hold_valid", out_valid, 1);
                    check("bp_hold_value", c_value, 1);
                    check("bp_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_got(4);
        expect_got("bp", 4, 1, 2, 3, 4);

        // Reset in the middle of a column discards the partial sum.
        send(1'b1, 1'b0, ramp(), fill(8'd2), 8'hFF, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_c_value", c_value, 0);
        send(1'b1, 1'b1, lane(0, 8'd5), lane(7, 8'd1), 8'h01, 8'h00);
        idle();
        wait_got(1);
        expect_got("rst_mid", 1, 5, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
